frame_fifo_fill_ctrl: RTL and testbench



---
 rtl/frame_fifo_fill_ctrl.sv | 182 ++++++++++++++++++
 tb/tb_frame_fifo_fill_ctrl.sv | 342 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/frame_fifo_fill_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : frame_fifo_fill_ctrl
// Purpose  : Walks a DDR framebuffer in read bursts and feeds frame_fifo.
// Revision : 1.0  initial release
// ============================================================================
module frame_fifo_fill_ctrl #(
    parameter int                ADDR_W          = 28,
    parameter logic [ADDR_W-1:0] FB0_BASE        = 'h000_0000,
    parameter logic [ADDR_W-1:0] FB1_BASE        = 'h001_0000,
    parameter int                FRAME_WORDS     = 38400,
    parameter int                BURST_LEN       = 32,
    parameter int                FIFO_RST_CYCLES = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              frame_start,
    input  logic              buf_sel,
    output logic              rd_req,
    output logic [ADDR_W-1:0] rd_addr,
    output logic [7:0]        rd_len,
    input  logic              rd_ack,
    input  logic              rd_dvalid,
    input  logic              rd_dlast,
    input  logic [127:0]      rd_data,
    output logic              fifo_wr_en,
    output logic [127:0]      fifo_wr_data,
    output logic              fifo_rst,
    input  logic              fifo_almost_full,
    input  logic              fifo_full,
    output logic              busy,
    output logic              frame_done,
    output logic              overflow_err
);

    localparam int                 c_CNT_W    = $clog2(FIFO_RST_CYCLES + 1);
    localparam logic [19:0]        c_FRAME    = 20'(FRAME_WORDS);
    localparam logic [19:0]        c_BURST    = 20'(BURST_LEN);
    localparam logic [7:0]         c_LEN_MAX  = 8'(BURST_LEN - 1);
    localparam logic [c_CNT_W-1:0] c_RST_LOAD = c_CNT_W'(FIFO_RST_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FRST  = 3'd1,
        S_WAIT  = 3'd2,
        S_REQ   = 3'd3,
        S_DATA  = 3'd4,
        S_FLUSH = 3'd5
    } state_t;

    state_t             r_state;
    logic [ADDR_W-1:0]  r_addr;
    logic [19:0]        r_remain;
    logic [c_CNT_W-1:0] r_rst_cnt;
    logic               r_restart;
    logic               r_pend_sel;

    logic [ADDR_W-1:0]  w_base_now;
    logic               w_pend_sel;
    logic [ADDR_W-1:0]  w_base_pend;
    logic [7:0]         w_len;
    logic [8:0]         w_step;
    logic               w_write;
    logic               w_last_beat;

    assign w_base_now  = buf_sel ? FB1_BASE : FB0_BASE;
    // A restart seen on the same cycle as rd_dlast still uses the fresh buf_sel.
    assign w_pend_sel  = frame_start ? buf_sel : r_pend_sel;
    assign w_base_pend = w_pend_sel ? FB1_BASE : FB0_BASE;
    assign w_len       = (r_remain < c_BURST) ? (r_remain[7:0] - 8'd1) : c_LEN_MAX;
    assign w_step      = {1'b0, rd_len} + 9'd1;
    // Once a restart is pending, the rest of the current burst is thrown away.
    assign w_write     = rd_dvalid && (r_state == S_DATA) && !r_restart;
    assign w_last_beat = rd_dvalid && rd_dlast;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_addr       <= '0;
            r_remain     <= '0;
            r_rst_cnt    <= '0;
            r_restart    <= 1'b0;
            r_pend_sel   <= 1'b0;
            rd_req       <= 1'b0;
            rd_addr      <= '0;
            rd_len       <= '0;
            fifo_wr_en   <= 1'b0;
            fifo_wr_data <= '0;
            fifo_rst     <= 1'b0;
            busy         <= 1'b0;
            frame_done   <= 1'b0;
            overflow_err <= 1'b0;
        end else begin
            fifo_wr_en <= w_write;
            frame_done <= 1'b0;
            if (w_write) begin
                fifo_wr_data <= rd_data;
            end
            if (w_write && fifo_full) begin
                overflow_err <= 1'b1;
            end

            case (r_state)
                S_IDLE: begin
                    if (frame_start) begin
                        r_addr    <= w_base_now;
                        r_remain  <= c_FRAME;
                        r_rst_cnt <= c_RST_LOAD;
                        fifo_rst  <= 1'b1;
                        busy      <= 1'b1;
                        r_state   <= S_FRST;
                    end
                end
                S_FRST: begin
                    if (frame_start) begin
                        r_addr    <= w_base_now;
                        r_remain  <= c_FRAME;
                        r_rst_cnt <= c_RST_LOAD;
                    end else if (r_rst_cnt == '0) begin
                        fifo_rst <= 1'b0;
                        r_state  <= S_WAIT;
                    end else begin
                        r_rst_cnt <= r_rst_cnt - 1'b1;
                    end
                end
                S_WAIT: begin
                    if (frame_start) begin
                        r_addr    <= w_base_now;
                        r_remain  <= c_FRAME;
                        r_rst_cnt <= c_RST_LOAD;
                        fifo_rst  <= 1'b1;
                        r_state   <= S_FRST;
                    end else if (!fifo_almost_full) begin
                        rd_req  <= 1'b1;
                        rd_addr <= r_addr;
                        rd_len  <= w_len;
                        r_state <= S_REQ;
                    end
                end
                S_REQ: begin
                    if (frame_start) begin
                        r_restart  <= 1'b1;
                        r_pend_sel <= buf_sel;
                    end
                    if (rd_ack) begin
                        rd_req   <= 1'b0;
                        r_addr   <= r_addr + ADDR_W'(w_step);
                        r_remain <= r_remain - 20'(w_step);
                        r_state  <= (r_restart || frame_start) ? S_FLUSH : S_DATA;
                    end
                end
                S_DATA, S_FLUSH: begin
                    if (frame_start) begin
                        r_restart  <= 1'b1;
                        r_pend_sel <= buf_sel;
                    end
                    if (w_last_beat) begin
                        if (r_restart || frame_start) begin
                            r_addr    <= w_base_pend;
                            r_remain  <= c_FRAME;
                            r_rst_cnt <= c_RST_LOAD;
                            r_restart <= 1'b0;
                            fifo_rst  <= 1'b1;
                            r_state   <= S_FRST;
                        end else if (r_remain == 20'd0) begin
                            frame_done <= 1'b1;
                            busy       <= 1'b0;
                            r_state    <= S_IDLE;
                        end else begin
                            r_state <= S_WAIT;
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_frame_fifo_fill_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_frame_fifo_fill_ctrl
// Purpose  : Directed self-checking bench for frame_fifo_fill_ctrl.
// Revision : 1.0  initial release
// ============================================================================
module tb_frame_fifo_fill_ctrl;

    localparam logic [27:0] FB0 = 28'h000_0100;
    localparam logic [27:0] FB1 = 28'h000_1000;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         frame_start = 1'b0;
    logic         buf_sel = 1'b0;
    logic         fifo_almost_full = 1'b0;
    logic         fifo_full;
    logic         rd_ack;
    logic         rd_dvalid;
    logic         rd_dlast;
    logic [127:0] rd_data;
    logic         rd_req;
    logic [27:0]  rd_addr;
    logic [7:0]   rd_len;
    logic         fifo_wr_en;
    logic [127:0] fifo_wr_data;
    logic         fifo_rst;
    logic         busy;
    logic         frame_done;
    logic         overflow_err;

    frame_fifo_fill_ctrl #(
        .ADDR_W          (28),
        .FB0_BASE        (FB0),
        .FB1_BASE        (FB1),
        .FRAME_WORDS     (100),
        .BURST_LEN       (32),
        .FIFO_RST_CYCLES (8)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .frame_start      (frame_start),
        .buf_sel          (buf_sel),
        .rd_req           (rd_req),
        .rd_addr          (rd_addr),
        .rd_len           (rd_len),
        .rd_ack           (rd_ack),
        .rd_dvalid        (rd_dvalid),
        .rd_dlast         (rd_dlast),
        .rd_data          (rd_data),
        .fifo_wr_en       (fifo_wr_en),
        .fifo_wr_data     (fifo_wr_data),
        .fifo_rst         (fifo_rst),
        .fifo_almost_full (fifo_almost_full),
        .fifo_full        (fifo_full),
        .busy             (busy),
        .frame_done       (frame_done),
        .overflow_err     (overflow_err)
    );

    always #5 clk = ~clk;

    // Monitor state, sampled 1 time unit after each rising edge
    int           cyc = 0;
    logic [127:0] wr_q[$];
    int           done_cnt = 0, done_bad = 0, beat_cnt = 0;
    int           req_hi = 0, req_rises = 0, last_gap = 0;
    int           rst_hi = 0, rst_rise_cyc = 0, rst_gap = 0, last_dlast_cyc = 0;
    logic         req_prev = 1'b0, rst_prev = 1'b0;

    always @(posedge clk) begin
        #1;
        cyc++;
        if (rd_dvalid && rd_dlast) last_dlast_cyc = cyc - 1;
        if (fifo_wr_en) wr_q.push_back(fifo_wr_data);
        if (frame_done) begin
            done_cnt++;
            if (!fifo_wr_en) done_bad++;
        end
        if (rd_dvalid) beat_cnt++;
        if (rd_req) req_hi++;
        if (rd_req && !req_prev) begin
            req_rises++;
            last_gap = cyc - last_dlast_cyc;
        end
        if (fifo_rst) rst_hi++;
        if (fifo_rst && !rst_prev) begin
            rst_rise_cyc = cyc;
            rst_gap      = cyc - last_dlast_cyc;
        end
        req_prev = rd_req;
        rst_prev = fifo_rst;
    end

    // Zero-wait memory model with programmable ack delay and fifo_full injection
    int          ack_delay = 0;
    int          full_beat = -1;
    logic [35:0] req_q[$];
    int          beat_num = 0;

    initial begin : g_mem
        int          beats_left;
        int          wait_cnt;
        logic [27:0] beat_addr;
        beats_left = 0;
        wait_cnt   = 0;
        beat_addr  = '0;
        rd_ack = 1'b0; rd_dvalid = 1'b0; rd_dlast = 1'b0; rd_data = '0; fifo_full = 1'b0;
        forever begin
            @(negedge clk);
            rd_ack = 1'b0; rd_dvalid = 1'b0; rd_dlast = 1'b0; fifo_full = 1'b0;
            if (!rst_n) begin
                beats_left = 0;
                wait_cnt   = 0;
            end else if (beats_left > 0) begin
                rd_dvalid = 1'b1;
                rd_data   = {100'h0, beat_addr};
                rd_dlast  = (beats_left == 1);
                fifo_full = (beat_num == full_beat);
                beat_addr = beat_addr + 28'd1;
                beats_left--;
                beat_num++;
            end else if (rd_req) begin
                if (wait_cnt >= ack_delay) begin
                    rd_ack     = 1'b1;
                    wait_cnt   = 0;
                    req_q.push_back({rd_addr, rd_len});
                    beat_addr  = rd_addr;
                    beats_left = int'(rd_len) + 1;
                end else begin
                    wait_cnt++;
                end
            end
        end
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    function automatic int stream_bad(input int base, input logic [27:0] start, input int n);
        int bad = 0;
        for (int i = 0; i < n; i++) begin
            if (base + i >= wr_q.size()) bad++;
            else if (wr_q[base + i] !== {100'h0, start + 28'(i)}) bad++;
        end
        return bad;
    endfunction

    function automatic logic [35:0] req_at(input int idx);
        if (idx >= req_q.size()) return '1;
        return req_q[idx];
    endfunction

    int start_cyc = 0;

    task automatic start_frame(input logic sel);
        @(negedge clk);
        frame_start = 1'b1;
        buf_sel     = sel;
        start_cyc   = cyc;
        @(negedge clk);
        frame_start = 1'b0;
        buf_sel     = 1'b0;
    endtask

    task automatic wait_done(input int base, input string tag);
        int n = 0;
        while (done_cnt == base && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check_eq({tag, "_done_timeout"}, 128'(n < 3000), 128'd1);
    endtask

    task automatic wait_beats(input int target, input string tag);
        int n = 0;
        while (beat_cnt < target && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check_eq({tag, "_beat_timeout"}, 128'(n < 3000), 128'd1);
    endtask

    task automatic wait_req(input string tag);
        int n = 0;
        while (!rd_req && n < 300) begin
            @(negedge clk);
            n++;
        end
        check_eq({tag, "_req_timeout"}, 128'(n < 300), 128'd1);
    endtask

    initial begin : g_main
        int wb, rb, db, rs, rh, rr, bb, rel;
        repeat (3) @(negedge clk);
        check_eq("rst_outs", 128'({rd_req, rd_addr, rd_len, fifo_wr_en, fifo_rst, busy, frame_done, overflow_err}), 128'd0);
        check_eq("rst_wr_data", fifo_wr_data, 128'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Basic frame
        wb = wr_q.size(); rb = req_q.size(); db = done_cnt; rs = rst_hi;
        start_frame(1'b0);
        check_eq("t1_busy", 128'(busy), 128'd1);
        wait_req("t1");
        check_eq("t1_req_lat", 128'(cyc - start_cyc), 128'd10);
        wait_done(db, "t1");
        repeat (3) @(negedge clk);
        check_eq("t1_nreq", 128'(req_q.size() - rb), 128'd4);
        check_eq("t1_req0", 128'(req_at(rb)),     128'({28'h000_0100, 8'd31}));
        check_eq("t1_req1", 128'(req_at(rb + 1)), 128'({28'h000_0120, 8'd31}));
        check_eq("t1_req2", 128'(req_at(rb + 2)), 128'({28'h000_0140, 8'd31}));
        check_eq("t1_req3", 128'(req_at(rb + 3)), 128'({28'h000_0160, 8'd3}));
        check_eq("t1_nwr", 128'(wr_q.size() - wb), 128'd100);
        check_eq("t1_data", 128'(stream_bad(wb, FB0, 100)), 128'd0);
        check_eq("t1_ndone", 128'(done_cnt - db), 128'd1);
        check_eq("t1_done_align", 128'(done_bad), 128'd0);
        check_eq("t1_rst_len", 128'(rst_hi - rs), 128'd8);
        check_eq("t1_rst_rise", 128'(rst_rise_cyc - start_cyc), 128'd1);
        check_eq("t1_req_gap", 128'(last_gap), 128'd2);
        check_eq("t1_idle", 128'({busy, rd_req, fifo_rst}), 128'd0);
        check_eq("t1_ovf", 128'(overflow_err), 128'd0);

        // Backpressure after the second burst
        wb = wr_q.size(); rb = req_q.size(); db = done_cnt; bb = beat_cnt;
        start_frame(1'b0);
        wait_beats(bb + 64, "t2");
        fifo_almost_full = 1'b1;
        rh = req_hi;
        repeat (50) @(negedge clk);
        check_eq("t2_hold", 128'(req_hi - rh), 128'd0);
        fifo_almost_full = 1'b0;
        rel = cyc;
        wait_req("t2");
        check_eq("t2_release_lat", 128'(cyc - rel), 128'd1);
        wait_done(db, "t2");
        check_eq("t2_nreq", 128'(req_q.size() - rb), 128'd4);
        check_eq("t2_req2", 128'(req_at(rb + 2)), 128'({28'h000_0140, 8'd31}));
        check_eq("t2_nwr", 128'(wr_q.size() - wb), 128'd100);
        check_eq("t2_data", 128'(stream_bad(wb, FB0, 100)), 128'd0);

        // Restart during beat 10 of burst 2
        wb = wr_q.size(); rb = req_q.size(); db = done_cnt; bb = beat_cnt; rs = rst_hi;
        start_frame(1'b0);
        wait_beats(bb + 41, "t3");
        frame_start = 1'b1;
        buf_sel     = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
        buf_sel     = 1'b0;
        wait_beats(bb + 64, "t3b");
        @(negedge clk);
        check_eq("t3_rst_gap", 128'(rst_gap), 128'd1);
        wait_done(db, "t3");
        check_eq("t3_nwr", 128'(wr_q.size() - wb), 128'd142);
        check_eq("t3_data_old", 128'(stream_bad(wb, FB0, 42)), 128'd0);
        check_eq("t3_data_new", 128'(stream_bad(wb + 42, FB1, 100)), 128'd0);
        check_eq("t3_req_new", 128'(req_at(rb + 2)), 128'({FB1, 8'd31}));
        check_eq("t3_ndone", 128'(done_cnt - db), 128'd1);
        check_eq("t3_rst_len", 128'(rst_hi - rs), 128'd16);

        // Restart while a request waits 20 cycles for its ack
        wb = wr_q.size(); rb = req_q.size(); db = done_cnt; rr = req_rises;
        ack_delay = 20;
        start_frame(1'b0);
        wait_req("t4");
        rh = req_hi - 1;
        repeat (5) @(negedge clk);
        frame_start = 1'b1;
        buf_sel     = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
        buf_sel     = 1'b0;
        begin
            int n = 0;
            while (req_q.size() == rb && n < 300) begin
                @(negedge clk);
                n++;
            end
            check_eq("t4_ack_timeout", 128'(n < 300), 128'd1);
        end
        ack_delay = 0;
        @(negedge clk);
        check_eq("t4_req_held", 128'(req_hi - rh), 128'd21);
        check_eq("t4_req_rises", 128'(req_rises - rr), 128'd1);
        wait_done(db, "t4");
        check_eq("t4_nwr", 128'(wr_q.size() - wb), 128'd100);
        check_eq("t4_data", 128'(stream_bad(wb, FB1, 100)), 128'd0);
        check_eq("t4_req_old", 128'(req_at(rb)), 128'({FB0, 8'd31}));
        check_eq("t4_req_new", 128'(req_at(rb + 1)), 128'({FB1, 8'd31}));
        check_eq("t4_ndone", 128'(done_cnt - db), 128'd1);

        // Overflow is sticky across frames and cleared only by reset
        db = done_cnt;
        full_beat = beat_num + 5;
        start_frame(1'b0);
        wait_done(db, "t5a");
        full_beat = -1;
        check_eq("t5_ovf_set", 128'(overflow_err), 128'd1);
        db = done_cnt;
        start_frame(1'b1);
        wait_done(db, "t5b");
        check_eq("t5_ovf_sticky", 128'(overflow_err), 128'd1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_eq("t5_ovf_rst", 128'(overflow_err), 128'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Asynchronous reset in the middle of a burst
        bb = beat_cnt;
        start_frame(1'b0);
        wait_beats(bb + 10, "t6");
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("t6_async_outs", 128'({rd_req, rd_addr, rd_len, fifo_wr_en, fifo_rst, busy, frame_done, overflow_err}), 128'd0);
        check_eq("t6_async_data", fifo_wr_data, 128'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        rh = req_hi;
        repeat (100) @(negedge clk);
        check_eq("t6_no_req", 128'(req_hi - rh), 128'd0);
        check_eq("t6_idle", 128'({busy, fifo_rst}), 128'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
